// File: rtl/cntr_pkg.sv
// ---------------------------------------------------------------------------
// cntr_pkg
//
// Shared definitions for the cntr_updn_gen counter engine:
//   - cntr_state_e : op-state encoding reported on the 'state' output
//   - STATE_W      : width of the op-state field
//   - next_state() : priority decode of the command inputs into an op-state
//
// Encodings are fixed because downstream logic decodes the 'state' output
// directly; 3'b110 and 3'b111 are never produced.
// ---------------------------------------------------------------------------
package cntr_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    INC  = 3'b010,
    INC2 = 3'b011,
    DEC  = 3'b100,
    DEC2 = 3'b101
  } cntr_state_e;

  // Priority decode of the command inputs. clr wins over load, load wins
  // over counting, and a simultaneous inc/dec cancels out into a hold that
  // reports IDLE. dbl only selects the stride of a count op.
  function automatic cntr_state_e next_state(
    input logic clr,
    input logic load,
    input logic inc,
    input logic dec,
    input logic dbl
  );
    cntr_state_e ns;
    ns = IDLE;
    if (clr) begin
      ns = IDLE;
    end else if (load) begin
      ns = LOAD;
    end else if (inc && dec) begin
      ns = IDLE;
    end else if (inc) begin
      ns = dbl ? INC2 : INC;
    end else if (dec) begin
      ns = dbl ? DEC2 : DEC;
    end else begin
      ns = IDLE;
    end
    return ns;
  endfunction

endpackage

// File: rtl/cntr_addsub.sv
// ---------------------------------------------------------------------------
// cntr_addsub
//
// Purely combinational (WIDTH+1)-bit adder/subtractor shared by all four
// count ops of cntr_updn_gen.
//
// Ports:
//   a      in  WIDTH  current count
//   b      in  WIDTH  operand (1 or step, muxed by the caller)
//   sub    in  1      0: a + b, 1: a - b
//   result out WIDTH  low WIDTH bits of the sum/difference (modulo wrap)
//   carry  out 1      carry-out for add, borrow for subtract
// ---------------------------------------------------------------------------
module cntr_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] ext;

  // Zero-extending both operands by one bit makes the MSB of the result the
  // carry on an add and the borrow (a < b) on a subtract, so one flag serves
  // both directions.
  always_comb begin
    if (sub) begin
      ext = {1'b0, a} - {1'b0, b};
    end else begin
      ext = {1'b0, a} + {1'b0, b};
    end
  end

  assign result = ext[WIDTH-1:0];
  assign carry  = ext[WIDTH];

endmodule

// File: rtl/cntr_updn_gen.sv
// ---------------------------------------------------------------------------
// cntr_updn_gen
//
// Parametrised loadable up/down counter with a registered op-state, runtime
// step size, enable, synchronous clear, overflow/underflow pulses and
// terminal-count flags. Output is registered: one cycle command-to-count.
//
// Build option:
//   CNTR_SAT_EN  when defined, up-ops clamp at all-ones and down-ops clamp at
//                zero instead of wrapping; ovf/unf still pulse whenever the
//                unclamped result would have wrapped.
//
// Parameters:
//   WIDTH    counter/data width in bits (>= 2)
//   RST_VAL  count value loaded by rst and clr
//
// Ports:
//   clk    in  1        rising-edge clock
//   rst    in  1        synchronous active-high reset (overrides en)
//   en     in  1        global enable; 0 holds count and state
//   clr    in  1        synchronous clear to RST_VAL
//   load   in  1        load d_in
//   inc    in  1        count up
//   dec    in  1        count down
//   dbl    in  1        with inc/dec: stride is step instead of 1
//   d_in   in  WIDTH    load value
//   step   in  WIDTH    stride for INC2/DEC2
//   d_out  out WIDTH    registered count
//   state  out 3        registered op applied on the last enabled edge
//   ovf    out 1        registered pulse: up-op carried out
//   unf    out 1        registered pulse: down-op borrowed
//   tc_hi  out 1        d_out is all ones
//   tc_lo  out 1        d_out is zero
// ---------------------------------------------------------------------------
module cntr_updn_gen
  import cntr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic               inc,
  input  logic               dec,
  input  logic               dbl,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [WIDTH-1:0]   step,
  output logic [WIDTH-1:0]   d_out,
  output logic [STATE_W-1:0] state,
  output logic               ovf,
  output logic               unf,
  output logic               tc_hi,
  output logic               tc_lo
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  cntr_state_e      op_state;
  cntr_state_e      state_q;
  cntr_state_e      state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             is_down;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;

  // Decode this edge's command into the op it would perform, and set up the
  // shared adder: direction from the op, stride from dbl.
  always_comb begin
    op_state = next_state(clr, load, inc, dec, dbl);
    is_down  = (op_state == DEC) || (op_state == DEC2);
    operand  = dbl ? step : ONE;
  end

  cntr_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a      (count_q),
    .b      (operand),
    .sub    (is_down),
    .result (sum),
    .carry  (carry)
  );

  // Next count, op-state and flags. The flags default low so that a disabled
  // edge, clr, load and the hold ops all clear any pending pulse; only an
  // up/down op that wraps raises one. IDLE covers clr as well as the two
  // hold cases, so clr is tested explicitly to pick RST_VAL.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (en) begin
      state_d = op_state;
      case (op_state)
        IDLE: begin
          if (clr) begin
            count_d = RST_VAL;
          end
        end
        LOAD: begin
          count_d = d_in;
        end
        INC, INC2: begin
          ovf_d = carry;
`ifdef CNTR_SAT_EN
          count_d = carry ? '1 : sum;
`else
          count_d = sum;
`endif
        end
        DEC, DEC2: begin
          unf_d = carry;
`ifdef CNTR_SAT_EN
          count_d = carry ? '0 : sum;
`else
          count_d = sum;
`endif
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // State register; reset takes effect regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign d_out = count_q;
  assign state = state_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign tc_hi = &count_q;
  assign tc_lo = ~|count_q;

endmodule

// File: tb/tb_cntr_updn_gen.sv
// ---------------------------------------------------------------------------
// tb_cntr_updn_gen
//
// Self-checking bench for cntr_updn_gen (WIDTH=8, RST_VAL=0). Directed vector
// table, hand-written multi-cycle sequences, then a seeded random sequence
// checked against a behavioural integer model. Expected values follow the
// CNTR_SAT_EN build option when it is defined.
// ---------------------------------------------------------------------------
module tb_cntr_updn_gen;

`ifdef CNTR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic       inc;
    logic       dec;
    logic       dbl;
    logic [7:0] d_in;
    logic [7:0] step;
    logic [7:0] exp_cnt;
    logic [2:0] exp_st;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       load;
  logic       inc;
  logic       dec;
  logic       dbl;
  logic [7:0] d_in;
  logic [7:0] step;
  logic [7:0] d_out;
  logic [2:0] state;
  logic       ovf;
  logic       unf;
  logic       tc_hi;
  logic       tc_lo;

  int   errors;
  int   checks;
  vec_t vecs[$];

  cntr_updn_gen #(
    .WIDTH   (8),
    .RST_VAL (8'h00)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .load  (load),
    .inc   (inc),
    .dec   (dec),
    .dbl   (dbl),
    .d_in  (d_in),
    .step  (step),
    .d_out (d_out),
    .state (state),
    .ovf   (ovf),
    .unf   (unf),
    .tc_hi (tc_hi),
    .tc_lo (tc_lo)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(
    input logic rst_i, input logic en_i, input logic clr_i, input logic load_i,
    input logic inc_i, input logic dec_i, input logic dbl_i,
    input logic [7:0] d_in_i, input logic [7:0] step_i,
    input logic [7:0] exp_cnt_i, input logic [2:0] exp_st_i,
    input logic exp_ovf_i, input logic exp_unf_i
  );
    vec_t v;
    v.rst = rst_i;  v.en = en_i;   v.clr = clr_i;  v.load = load_i;
    v.inc = inc_i;  v.dec = dec_i; v.dbl = dbl_i;
    v.d_in = d_in_i; v.step = step_i;
    v.exp_cnt = exp_cnt_i; v.exp_st = exp_st_i;
    v.exp_ovf = exp_ovf_i; v.exp_unf = exp_unf_i;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle past it.
  task automatic applyStimulus(
    input logic rst_i, input logic en_i, input logic clr_i, input logic load_i,
    input logic inc_i, input logic dec_i, input logic dbl_i,
    input logic [7:0] d_in_i, input logic [7:0] step_i
  );
    rst = rst_i;  en = en_i;   clr = clr_i;  load = load_i;
    inc = inc_i;  dec = dec_i; dbl = dbl_i;
    d_in = d_in_i; step = step_i;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(
    input string tag, input logic [7:0] exp_cnt, input logic [2:0] exp_st,
    input logic exp_ovf, input logic exp_unf
  );
    checkOne({tag, " d_out"}, d_out, exp_cnt);
    checkOne({tag, " state"}, {5'd0, state}, {5'd0, exp_st});
    checkOne({tag, " ovf"}, {7'd0, ovf}, {7'd0, exp_ovf});
    checkOne({tag, " unf"}, {7'd0, unf}, {7'd0, exp_unf});
    checkOne({tag, " tc_hi"}, {7'd0, tc_hi}, {7'd0, (exp_cnt == 8'hFF)});
    checkOne({tag, " tc_lo"}, {7'd0, tc_lo}, {7'd0, (exp_cnt == 8'h00)});
  endtask

  // Behavioural reference for the random phase.
  int m_cnt;
  int m_st;
  int m_ovf;
  int m_unf;

  task automatic modelStep(
    input logic r, input logic e, input logic c, input logic l,
    input logic i, input logic d, input logic b, input int din, input int stp
  );
    int s;
    int t;
    s = b ? stp : 1;
    m_ovf = 0;
    m_unf = 0;
    if (r) begin
      m_cnt = 0; m_st = 0;
    end else if (!e) begin
      m_cnt = m_cnt;
    end else if (c) begin
      m_cnt = 0; m_st = 0;
    end else if (l) begin
      m_cnt = din; m_st = 1;
    end else if (i && d) begin
      m_st = 0;
    end else if (i) begin
      t = m_cnt + s;
      m_st = b ? 3 : 2;
      if (t > 255) begin
        m_ovf = 1;
        m_cnt = SAT ? 255 : t - 256;
      end else begin
        m_cnt = t;
      end
    end else if (d) begin
      t = m_cnt - s;
      m_st = b ? 5 : 4;
      if (t < 0) begin
        m_unf = 1;
        m_cnt = SAT ? 0 : t + 256;
      end else begin
        m_cnt = t;
      end
    end else begin
      m_st = 0;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; en = 1'b1; clr = 1'b0; load = 1'b0;
    inc = 1'b0; dec = 1'b0; dbl = 1'b0; d_in = 8'h00; step = 8'h00;

    //     rst en clr ld inc dec dbl d_in   step   exp_cnt                 st    ovf unf
    addVec(1, 1, 0, 1, 0, 0, 0, 8'h55, 8'h00, 8'h00,                  3'd0, 0, 0);
    addVec(1, 1, 0, 1, 0, 0, 0, 8'h55, 8'h00, 8'h00,                  3'd0, 0, 0);
    addVec(0, 1, 0, 1, 0, 0, 0, 8'hFE, 8'h00, 8'hFE,                  3'd1, 0, 0);
    addVec(0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'hFF,                  3'd2, 0, 0);
    addVec(0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, SAT ? 8'hFF : 8'h00,    3'd2, 1, 0);
    addVec(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, SAT ? 8'hFF : 8'h00,    3'd0, 0, 0);
    addVec(0, 1, 0, 1, 0, 0, 0, 8'h03, 8'h00, 8'h03,                  3'd1, 0, 0);
    addVec(0, 1, 0, 0, 0, 1, 1, 8'h00, 8'h05, SAT ? 8'h00 : 8'hFE,    3'd5, 0, 1);
    addVec(0, 1, 0, 1, 0, 0, 0, 8'h10, 8'h00, 8'h10,                  3'd1, 0, 0);
    addVec(0, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h10,                  3'd0, 0, 0);
    addVec(0, 1, 0, 1, 1, 0, 0, 8'h7A, 8'h00, 8'h7A,                  3'd1, 0, 0);
    addVec(0, 1, 0, 1, 0, 0, 0, 8'h20, 8'h00, 8'h20,                  3'd1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h20,                  3'd1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h20,                  3'd1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h20,                  3'd1, 0, 0);
    addVec(0, 1, 1, 1, 0, 0, 0, 8'h99, 8'h00, 8'h00,                  3'd0, 0, 0);
    addVec(0, 1, 0, 1, 0, 0, 0, 8'h80, 8'h00, 8'h80,                  3'd1, 0, 0);
    addVec(0, 1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h80,                  3'd3, 0, 0);
    addVec(0, 1, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h80,                  3'd5, 0, 0);
    addVec(0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h7F,                  3'd4, 0, 0);
    addVec(0, 1, 0, 0, 1, 0, 1, 8'h00, 8'h81, SAT ? 8'hFF : 8'h00,    3'd3, 1, 0);
    addVec(0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00,                  3'd1, 0, 0);
    addVec(0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, SAT ? 8'h00 : 8'hFF,    3'd4, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].load,
                    vecs[i].inc, vecs[i].dec, vecs[i].dbl,
                    vecs[i].d_in, vecs[i].step);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_st,
                  vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // Back-to-back wrapping up-ops keep ovf high; a disabled edge drops it.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 8'hFF, 8'h00);
    checkOutput("b2b load", 8'hFF, 3'd1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 8'h00, 8'hFF);
    checkOutput("b2b inc2 a", SAT ? 8'hFF : 8'hFE, 3'd3, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 8'h00, 8'hFF);
    checkOutput("b2b inc2 b", SAT ? 8'hFF : 8'hFD, 3'd3, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'hFF);
    checkOutput("en0 drops ovf", SAT ? 8'hFF : 8'hFD, 3'd3, 0, 0);

    // A borrow pulse followed by clr: clr clears both count and flag.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 8'h01, 8'h00);
    checkOutput("unf load", 8'h01, 3'd1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 8'h00, 8'h02);
    checkOutput("unf dec2", SAT ? 8'h00 : 8'hFF, 3'd5, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 8'h00, 8'h00);
    checkOutput("unf clr", 8'h00, 3'd0, 0, 0);

    // Reset wins even with en low.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 8'h3C, 8'h00);
    checkOutput("pre rst load", 8'h3C, 3'd1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 8'h77, 8'h00);
    checkOutput("rst with en0", 8'h00, 3'd0, 0, 0);

    // Random sequence against the behavioural model.
    m_cnt = 0; m_st = 0; m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 1000; n++) begin
      logic r, e, c, l, i, d, b;
      logic [7:0] din, stp;
      r   = ($urandom_range(0, 63) == 0);
      e   = ($urandom_range(0, 7) != 0);
      c   = ($urandom_range(0, 31) == 0);
      l   = ($urandom_range(0, 7) == 0);
      i   = $urandom_range(0, 1) == 1;
      d   = $urandom_range(0, 1) == 1;
      b   = $urandom_range(0, 1) == 1;
      din = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      applyStimulus(r, e, c, l, i, d, b, din, stp);
      modelStep(r, e, c, l, i, d, b, int'(din), int'(stp));
      checkOutput($sformatf("rnd%0d", n), 8'(m_cnt), 3'(m_st), m_ovf[0], m_unf[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
